edge_acc_param: RTL and testbench

//  Parametrised Sobel edge-detection accelerator, successor to the fixed 352x288 task-2 engine.
//  - Reads an 8-bit greyscale image from word-addressed memory, 4 pixels per 32-bit word.
//  - Computes the Sobel magnitude for every interior pixel and writes the result image to a

---
 rtl/edge_pkg.sv | 37 +++
 rtl/edge_acc_param_if.sv | 14 +
 rtl/edge_window.sv | 76 +++++++
 rtl/edge_acc_param.sv | 186 ++++++++++++++++++
 tb/tb_edge_acc_param.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_pkg.sv
// Shared types and arithmetic for the Sobel edge accelerator: FSM state encoding,
// pixel/word geometry and the saturating gradient-magnitude helper.
package edge_pkg;

   localparam int PIX_W        = 8;
   localparam int PIX_PER_WORD = 4;
   localparam int WORD_W       = PIX_W * PIX_PER_WORD;
   localparam int GRAD_W       = 11;

   typedef enum logic [2:0] {
      IDLE,
      BRD_WR,
      RD0,
      RD1,
      RD2,
      SHIFT,
      WR,
      DONE
   } edge_state_t;

   // |gx| + |gy| fits in GRAD_W+1 bits; anything above 8 bits clips to 255.
   function automatic logic [PIX_W-1:0] sobel_mag(input logic signed [GRAD_W-1:0] gx,
                                                  input logic signed [GRAD_W-1:0] gy);
      logic signed [GRAD_W:0] gx_e;
      logic signed [GRAD_W:0] gy_e;
      logic [GRAD_W:0]        ax;
      logic [GRAD_W:0]        ay;
      logic [GRAD_W:0]        sum;
      gx_e = gx;
      gy_e = gy;
      ax   = gx_e[GRAD_W] ? -gx_e : gx_e;
      ay   = gy_e[GRAD_W] ? -gy_e : gy_e;
      sum  = ax + ay;
      return (|sum[GRAD_W:PIX_W]) ? '1 : sum[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/edge_acc_param_if.sv
// Word-addressed shared data memory port used by the edge accelerator.
interface edge_acc_param_if;
   import edge_pkg::*;

   logic [15:0]       addr;
   logic [WORD_W-1:0] dataR;
   logic [WORD_W-1:0] dataW;
   logic              en;
   logic              we;

   modport master (output addr, output dataW, output en, output we, input dataR);
   modport slave  (input addr, input dataW, input en, input we, output dataR);

endinterface

// File: rtl/edge_window.sv
// 3-row x 3-word (L,C,R) pixel window with staging for the first two rows of a new
// column, plus four Sobel kernels producing the magnitudes of the pixels in word C.
module edge_window
   import edge_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 ld_i,
   input  logic                                 ld_sel_i,
   input  logic                                 shift_i,
   input  logic                                 zero_i,
   input  logic [WORD_W-1:0]                    din_i,
   output logic [PIX_PER_WORD-1:0][PIX_W-1:0]   mag_o
);

   logic [2:0][2:0][WORD_W-1:0] win_q, win_d;
   logic [1:0][WORD_W-1:0]      stg_q, stg_d;
   logic [2:0][PIX_PER_WORD+1:0][PIX_W-1:0] px;

   function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed({{(GRAD_W-PIX_W){1'b0}}, p});
   endfunction

   // Rows 0/1 of the incoming column wait in staging; row 2 arrives with the shift.
   always_comb begin
      win_d = win_q;
      stg_d = stg_q;
      if (ld_i) begin
         stg_d[ld_sel_i] = din_i;
      end
      if (shift_i) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = zero_i ? '0 : stg_q[0];
         win_d[1][2] = zero_i ? '0 : stg_q[1];
         win_d[2][2] = zero_i ? '0 : din_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q <= '0;
         stg_q <= '0;
      end else begin
         win_q <= win_d;
         stg_q <= stg_d;
      end
   end

   // px[r] = {R.pix0, C.pix3..C.pix0, L.pix3}: six adjacent pixels around word C.
   always_comb begin
      px = '0;
      for (int r = 0; r < 3; r++) begin
         px[r][0] = win_q[r][0][WORD_W-1 -: PIX_W];
         for (int i = 0; i < PIX_PER_WORD; i++) begin
            px[r][i+1] = win_q[r][1][i*PIX_W +: PIX_W];
         end
         px[r][PIX_PER_WORD+1] = win_q[r][2][PIX_W-1:0];
      end
   end

   for (genvar i = 0; i < PIX_PER_WORD; i++) begin : g_kernel
      logic signed [GRAD_W-1:0] gx;
      logic signed [GRAD_W-1:0] gy;
      always_comb begin
         gx = (ext(px[0][i+2]) + (ext(px[1][i+2]) <<< 1) + ext(px[2][i+2]))
            - (ext(px[0][i])   + (ext(px[1][i])   <<< 1) + ext(px[2][i]));
         gy = (ext(px[2][i]) + (ext(px[2][i+1]) <<< 1) + ext(px[2][i+2]))
            - (ext(px[0][i]) + (ext(px[0][i+1]) <<< 1) + ext(px[0][i+2]));
      end
      assign mag_o[i] = sobel_mag(gx, gy);
   end

endmodule

// File: rtl/edge_acc_param.sv
// Parametrised Sobel edge accelerator: border rows first, then interior rows word by word.
// Optional build macro EDGE_ACC_THRESH_EN adds a threshold input that binarises results.
module edge_acc_param
   import edge_pkg::*;
#(
   parameter int               IMG_W      = 352,
   parameter int               IMG_H      = 288,
   parameter int               IN_BASE    = 0,
   parameter int               OUT_BASE   = 25344,
   parameter logic [PIX_W-1:0] BORDER_VAL = 8'h00
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
`ifdef EDGE_ACC_THRESH_EN
   input  logic [PIX_W-1:0]  threshold,
`endif
   output logic              finish,
   edge_acc_param_if.master  mem
);

   localparam int WPR = IMG_W / PIX_PER_WORD;
   localparam int JW  = $clog2(2*WPR + 1);
   localparam int YW  = $clog2(IMG_H);
   localparam logic [JW-1:0] J_ONE      = JW'(1);
   localparam logic [JW-1:0] J_WPR      = JW'(WPR);
   localparam logic [JW-1:0] J_BRD_LAST = JW'(2*WPR - 1);
   localparam logic [YW-1:0] Y_FIRST    = YW'(1);
   localparam logic [YW-1:0] Y_LAST     = YW'(IMG_H - 2);

   edge_state_t state_q, state_d;
   logic [YW-1:0] y_q, y_d;
   logic [JW-1:0] j_q, j_d;

   logic win_ld, win_sel, win_shift, win_zero;
   logic [PIX_PER_WORD-1:0][PIX_W-1:0] mag;
   logic [PIX_PER_WORD-1:0][PIX_W-1:0] res;

`ifdef EDGE_ACC_THRESH_EN
   logic [PIX_W-1:0] thr_q, thr_d;
`endif

   function automatic logic [15:0] waddr(input int base, input int row, input int word);
      return 16'(base + row*WPR + word);
   endfunction

   edge_window u_window (
      .clk      (clk),
      .rst_n    (reset_n),
      .ld_i     (win_ld),
      .ld_sel_i (win_sel),
      .shift_i  (win_shift),
      .zero_i   (win_zero),
      .din_i    (mem.dataR),
      .mag_o    (mag)
   );

   // In WR, j-1 is the output word: j==1 holds column 0, j==WPR holds column IMG_W-1.
   always_comb begin
      for (int i = 0; i < PIX_PER_WORD; i++) begin
`ifdef EDGE_ACC_THRESH_EN
         res[i] = (mag[i] >= thr_q) ? '1 : '0;
`else
         res[i] = mag[i];
`endif
      end
      if (j_q == J_ONE) begin
         res[0] = BORDER_VAL;
      end
      if (j_q == J_WPR) begin
         res[PIX_PER_WORD-1] = BORDER_VAL;
      end
   end

   always_comb begin
      state_d   = state_q;
      y_d       = y_q;
      j_d       = j_q;
      finish    = 1'b0;
      mem.en    = 1'b0;
      mem.we    = 1'b0;
      mem.addr  = '0;
      mem.dataW = '0;
      win_ld    = 1'b0;
      win_sel   = 1'b0;
      win_shift = 1'b0;
      win_zero  = 1'b0;
`ifdef EDGE_ACC_THRESH_EN
      thr_d     = thr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               j_d     = '0;
               state_d = BRD_WR;
`ifdef EDGE_ACC_THRESH_EN
               thr_d   = threshold;
`endif
            end
         end
         BRD_WR: begin
            mem.en    = 1'b1;
            mem.we    = 1'b1;
            mem.dataW = {PIX_PER_WORD{BORDER_VAL}};
            mem.addr  = (j_q < J_WPR) ? waddr(OUT_BASE, 0, int'(j_q))
                                      : waddr(OUT_BASE, IMG_H-1, int'(j_q) - WPR);
            j_d = j_q + J_ONE;
            if (j_q == J_BRD_LAST) begin
               y_d     = Y_FIRST;
               j_d     = '0;
               state_d = RD0;
            end
         end
         RD0: begin
            mem.en   = 1'b1;
            mem.addr = waddr(IN_BASE, int'(y_q) - 1, int'(j_q));
            state_d  = RD1;
         end
         RD1: begin
            mem.en   = 1'b1;
            mem.addr = waddr(IN_BASE, int'(y_q), int'(j_q));
            win_ld   = 1'b1;
            state_d  = RD2;
         end
         RD2: begin
            mem.en   = 1'b1;
            mem.addr = waddr(IN_BASE, int'(y_q) + 1, int'(j_q));
            win_ld   = 1'b1;
            win_sel  = 1'b1;
            state_d  = SHIFT;
         end
         SHIFT: begin
            win_shift = 1'b1;
            win_zero  = (j_q == J_WPR);
            if (j_q == '0) begin
               j_d     = J_ONE;
               state_d = RD0;
            end else begin
               state_d = WR;
            end
         end
         WR: begin
            mem.en    = 1'b1;
            mem.we    = 1'b1;
            mem.addr  = waddr(OUT_BASE, int'(y_q), int'(j_q) - 1);
            mem.dataW = res;
            if (j_q != J_WPR) begin
               j_d     = j_q + J_ONE;
               state_d = ((j_q + J_ONE) == J_WPR) ? SHIFT : RD0;
            end else if (y_q == Y_LAST) begin
               state_d = DONE;
            end else begin
               y_d     = y_q + Y_FIRST;
               j_d     = '0;
               state_d = RD0;
            end
         end
         DONE: begin
            finish = 1'b1;
            if (!start) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         y_q     <= '0;
         j_q     <= '0;
`ifdef EDGE_ACC_THRESH_EN
         thr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         j_q     <= j_d;
`ifdef EDGE_ACC_THRESH_EN
         thr_q   <= thr_d;
`endif
      end
   end

endmodule

// File: tb/tb_edge_acc_param.sv
// Directed/random bench for edge_acc_param: an 8x4 and a 16x5 instance, each with a
// word memory model, checked against a plain-arithmetic Sobel reference image.
module tb_edge_acc_param;

   localparam int AW = 8;
   localparam int AH = 4;
   localparam int A_OUT = 16;
   localparam int A_WORDS = AW/4*AH;
   localparam int BW = 16;
   localparam int BH = 5;
   localparam int B_OUT = 32;
   localparam int B_WORDS = BW/4*BH;
   localparam logic [7:0] A_BRD = 8'h00;
   localparam logic [7:0] B_BRD = 8'h5A;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_na, rst_nb, start_a, start_b, finish_a, finish_b;
`ifdef EDGE_ACC_THRESH_EN
   logic [7:0] thr = 8'h40;
`endif

   edge_acc_param_if ifa ();
   edge_acc_param_if ifb ();

   edge_acc_param #(.IMG_W(AW), .IMG_H(AH), .IN_BASE(0), .OUT_BASE(A_OUT), .BORDER_VAL(A_BRD)) dut_a (
      .clk(clk), .reset_n(rst_na), .start(start_a),
`ifdef EDGE_ACC_THRESH_EN
      .threshold(thr),
`endif
      .finish(finish_a), .mem(ifa));

   edge_acc_param #(.IMG_W(BW), .IMG_H(BH), .IN_BASE(0), .OUT_BASE(B_OUT), .BORDER_VAL(B_BRD)) dut_b (
      .clk(clk), .reset_n(rst_nb), .start(start_b),
`ifdef EDGE_ACC_THRESH_EN
      .threshold(thr),
`endif
      .finish(finish_b), .mem(ifb));

   logic [31:0] in_a [0:A_WORDS-1];
   logic [31:0] out_a [0:A_WORDS-1];
   int          wcnt_a [0:A_WORDS-1];
   logic [31:0] in_b [0:B_WORDS-1];
   logic [31:0] out_b [0:B_WORDS-1];
   int          wcnt_b [0:B_WORDS-1];
   int stray_a = 0, stray_b = 0, wr_evt_a = 0, wr_evt_b = 0;
   logic clr_a = 1'b0, clr_b = 1'b0;

   always @(posedge clk) begin
      if (clr_a) begin
         for (int i = 0; i < A_WORDS; i++) begin
            out_a[i]  <= 32'hDEADBEEF;
            wcnt_a[i] <= 0;
         end
      end else if (ifa.en && ifa.we) begin
         wr_evt_a <= wr_evt_a + 1;
         if (int'(ifa.addr) >= A_OUT && int'(ifa.addr) < A_OUT + A_WORDS) begin
            out_a[int'(ifa.addr) - A_OUT]  <= ifa.dataW;
            wcnt_a[int'(ifa.addr) - A_OUT] <= wcnt_a[int'(ifa.addr) - A_OUT] + 1;
         end else begin
            stray_a <= stray_a + 1;
         end
      end
      if (ifa.en && !ifa.we) begin
         ifa.dataR <= (int'(ifa.addr) < A_WORDS) ? in_a[int'(ifa.addr)] : 32'h0;
      end
   end

   always @(posedge clk) begin
      if (clr_b) begin
         for (int i = 0; i < B_WORDS; i++) begin
            out_b[i]  <= 32'hDEADBEEF;
            wcnt_b[i] <= 0;
         end
      end else if (ifb.en && ifb.we) begin
         wr_evt_b <= wr_evt_b + 1;
         if (int'(ifb.addr) >= B_OUT && int'(ifb.addr) < B_OUT + B_WORDS) begin
            out_b[int'(ifb.addr) - B_OUT]  <= ifb.dataW;
            wcnt_b[int'(ifb.addr) - B_OUT] <= wcnt_b[int'(ifb.addr) - B_OUT] + 1;
         end else begin
            stray_b <= stray_b + 1;
         end
      end
      if (ifb.en && !ifb.we) begin
         ifb.dataR <= (int'(ifb.addr) < B_WORDS) ? in_b[int'(ifb.addr)] : 32'h0;
      end
   end

   logic [7:0] pix [0:4][0:15];
   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int px(input int x, input int y);
      return int'(pix[y][x]);
   endfunction

   function automatic logic [7:0] ref_pix(input int x, input int y, input int w, input int h,
                                          input logic [7:0] bval);
      int gx, gy, m;
      if (x == 0 || y == 0 || x == w-1 || y == h-1) return bval;
      gx = (px(x+1,y-1) + 2*px(x+1,y) + px(x+1,y+1)) - (px(x-1,y-1) + 2*px(x-1,y) + px(x-1,y+1));
      gy = (px(x-1,y+1) + 2*px(x,y+1) + px(x+1,y+1)) - (px(x-1,y-1) + 2*px(x,y-1) + px(x+1,y-1));
      m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (m > 255) m = 255;
`ifdef EDGE_ACC_THRESH_EN
      return (m >= int'(thr)) ? 8'hFF : 8'h00;
`else
      return 8'(m);
`endif
   endfunction

   function automatic logic [31:0] ref_word(input int k, input int y, input int w, input int h,
                                            input logic [7:0] bval);
      logic [31:0] wd;
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = ref_pix(4*k + i, y, w, h, bval);
      return wd;
   endfunction

   function automatic int exp_cycles(input int w, input int h);
      return 2*(w/4) + (h-2)*(5*(w/4) + 1) + 2;
   endfunction

   function automatic logic fin(input int which);
      return (which != 0) ? finish_b : finish_a;
   endfunction

   function automatic int wr_evt(input int which);
      return (which != 0) ? wr_evt_b : wr_evt_a;
   endfunction

   task automatic fill(input int mode, input int w, input int h);
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 16; x++) begin
            case (mode)
               0: pix[y][x] = 8'h80;
               1: pix[y][x] = (x >= 4) ? 8'hFF : 8'h00;
               2: pix[y][x] = 8'($urandom_range(0, 255));
               3: pix[y][x] = 8'($urandom_range(0, 40));
               default: pix[y][x] = 8'h00;
            endcase
         end
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            if (w == AW) in_a[y*(w/4) + x/4][8*(x%4) +: 8] = pix[y][x];
            else         in_b[y*(w/4) + x/4][8*(x%4) +: 8] = pix[y][x];
         end
   endtask

   task automatic run(input int which, output int cyc);
      int ev;
      if (which != 0) clr_b = 1'b1; else clr_a = 1'b1;
      @(posedge clk); #1;
      clr_a = 1'b0;
      clr_b = 1'b0;
      if (which != 0) start_b = 1'b1; else start_a = 1'b1;
      cyc = 0;
      while (fin(which) == 1'b0 && cyc < 5000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("finish_reached", 32'(fin(which)), 32'd1);
      ev = wr_evt(which);
      repeat (3) @(posedge clk);
      #1;
      check("finish_held", 32'(fin(which)), 32'd1);
      check("no_rerun_in_done", 32'(wr_evt(which) - ev), 32'd0);
      start_a = 1'b0;
      start_b = 1'b0;
      @(posedge clk); #1;
      check("finish_cleared", 32'(fin(which)), 32'd0);
   endtask

   task automatic check_image(input int which, input string tag);
      int w, h;
      logic [7:0] bv;
      w  = (which != 0) ? BW : AW;
      h  = (which != 0) ? BH : AH;
      bv = (which != 0) ? B_BRD : A_BRD;
      for (int y = 0; y < h; y++)
         for (int k = 0; k < w/4; k++) begin
            if (which != 0) begin
               check($sformatf("%s_y%0d_k%0d", tag, y, k), out_b[y*(w/4)+k], ref_word(k, y, w, h, bv));
               check($sformatf("%s_wcnt_y%0d_k%0d", tag, y, k), 32'(wcnt_b[y*(w/4)+k]), 32'd1);
            end else begin
               check($sformatf("%s_y%0d_k%0d", tag, y, k), out_a[y*(w/4)+k], ref_word(k, y, w, h, bv));
               check($sformatf("%s_wcnt_y%0d_k%0d", tag, y, k), 32'(wcnt_a[y*(w/4)+k]), 32'd1);
            end
         end
      check({tag, "_stray_writes"}, 32'((which != 0) ? stray_b : stray_a), 32'd0);
   endtask

   initial begin
      int cyc, ev;
      logic [31:0] wd;
      logic [7:0] b;
      rst_na  = 1'b0;
      rst_nb  = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      #12;
      check("rst_finish", 32'(finish_a), 32'd0);
      check("rst_en", 32'(ifa.en), 32'd0);
      check("rst_we", 32'(ifa.we), 32'd0);
      check("rst_addr", 32'(ifa.addr), 32'd0);
      check("rst_dataW", ifa.dataW, 32'd0);
      check("rst_finish_b", 32'(finish_b), 32'd0);
      @(posedge clk); #1;
      rst_na = 1'b1;
      rst_nb = 1'b1;

      // flat grey image: no gradient anywhere
      fill(0, AW, AH);
      run(0, cyc);
      check("flat_cycles", 32'(cyc + 1), 32'd28);
      for (int i = 0; i < A_WORDS; i++) check($sformatf("flat_w%0d", i), out_a[i], 32'h0);
      check_image(0, "flat");

      // vertical step between x=3 and x=4
      fill(1, AW, AH);
      run(0, cyc);
      for (int y = 0; y < AH; y++) begin
         check($sformatf("step_y%0d_k0", y), out_a[2*y], (y == 1 || y == 2) ? 32'hFF000000 : 32'h0);
         check($sformatf("step_y%0d_k1", y), out_a[2*y+1], (y == 1 || y == 2) ? 32'h000000FF : 32'h0);
      end
      check_image(0, "step");

      fill(2, AW, AH);
      run(0, cyc);
      check("rand_a_cycles", 32'(cyc + 1), 32'(exp_cycles(AW, AH)));
      check_image(0, "rand_a");

      fill(3, AW, AH);
      run(0, cyc);
      check_image(0, "low_a");

      // asynchronous reset in RD1 of row 2, then a clean rerun
      fill(2, AW, AH);
      clr_a = 1'b1;
      @(posedge clk); #1;
      clr_a = 1'b0;
      start_a = 1'b1;
      @(posedge clk); #1;
      repeat (16) @(posedge clk);
      #1;
      check("rd1_row2_en", 32'(ifa.en), 32'd1);
      check("rd1_row2_we", 32'(ifa.we), 32'd0);
      check("rd1_row2_addr", 32'(ifa.addr), 32'd4);
      #2 rst_na = 1'b0;
      #1;
      check("midrst_en", 32'(ifa.en), 32'd0);
      check("midrst_we", 32'(ifa.we), 32'd0);
      check("midrst_finish", 32'(finish_a), 32'd0);
      start_a = 1'b0;
      ev = wr_evt_a;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_no_writes", 32'(wr_evt_a - ev), 32'd0);
      rst_na = 1'b1;
      @(posedge clk); #1;
      check("midrst_idle", 32'(finish_a), 32'd0);
      run(0, cyc);
      check("rerun_cycles", 32'(cyc + 1), 32'(exp_cycles(AW, AH)));
      check_image(0, "rerun");

      // single bright pixel at (3,2) in the 16x5 image
      fill(4, BW, BH);
      pix[2][3] = 8'hFF;
      in_b[2*(BW/4)][31:24] = 8'hFF;
      run(1, cyc);
      check("dot_cycles", 32'(cyc + 1), 32'(exp_cycles(BW, BH)));
      for (int y = 1; y <= 3; y++)
         for (int x = 2; x <= 4; x++) begin
            wd = out_b[y*(BW/4) + x/4];
            b  = wd[8*(x%4) +: 8];
            check($sformatf("dot_x%0d_y%0d", x, y), 32'(b), (x == 3 && y == 2) ? 32'h00 : 32'hFF);
         end
      check_image(1, "dot");

      fill(2, BW, BH);
      run(1, cyc);
      check_image(1, "rand_b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
